gpio_debounce: RTL
==================

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 Parameter BUS_WIDTH, default 8: number of GPIO input bits handled; legal range 1..16.
REQ-002 Parameter PRESCALE, default 1: clock cycles per debounce sample tick; must be 1 or more.
REQ-003 Parameter DEBOUNCE_TICKS, default 4: number of consecutive mismatching ticks needed to accept a new level; must be 1 or more.
REQ-004 Parameter INIT_VAL, default 'h00: reset value of the synchronizer flops and of gpio_o.
REQ-005 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 gpio_i  input  BUS_WIDTH  raw pad input values, asynchronous to clk_i.
REQ-008 bypass_i  input  BUS_WIDTH  per-bit debounce bypass; 1 = bit i is synchronized only.
REQ-009 gpio_o  output  BUS_WIDTH  debounced level; feeds the gpio_i port of gpio_ahbl.
REQ-010 rise_o  output  BUS_WIDTH  one-cycle pulse per bit when gpio_o[i] goes 0->1.
REQ-011 fall_o  output  BUS_WIDTH  one-cycle pulse per bit when gpio_o[i] goes 1->0.
REQ-012 change_o  output  1  registered OR of all rise_o and fall_o bits, asserted in the same cycle as them.

Function
REQ-013 Each gpio_i bit shall pass through a 2-flop synchronizer (sync1, then sync2); debounce logic uses sync2 only.
REQ-014 Prescaler: a shared counter runs 0..PRESCALE-1 and wraps to 0; tick is high in the cycle where count == PRESCALE-1.
REQ-015 If PRESCALE == 1, tick shall be high every cycle.
REQ-016 Each bit shall have its own stable counter, CNT_W = max(1, clog2(DEBOUNCE_TICKS)) bits wide.
REQ-017 Match case: when sync2[i] == gpio_o[i], cnt[i] shall clear to 0 in that cycle, independent of tick.
REQ-018 Mismatch with tick, below threshold: cnt[i] < DEBOUNCE_TICKS-1 shall increment cnt[i].
REQ-019 Mismatch with tick, at threshold: cnt[i] == DEBOUNCE_TICKS-1 shall load gpio_o[i] <= sync2[i] and clear cnt[i].
REQ-020 Mismatch without tick: cnt[i] shall hold its value.
REQ-021 Any glitch that returns to the gpio_o level before acceptance shall restart the count from 0; no partial credit is kept.
REQ-022 Bypass: bypass_i[i]=1 shall load gpio_o[i] <= sync2[i] every cycle and hold cnt[i] at 0; edge pulses are still generated.
REQ-023 bypass_i changes shall take effect on the next clock edge; a 1->0 change shall start debouncing from the current gpio_o value with cnt=0.
REQ-024 rise_o, fall_o and change_o shall be registered and decoded from the next-state versus current-state of gpio_o, so each pulse is high in exactly the cycle where gpio_o shows the new value.
REQ-025 Bits shall be fully independent; simultaneous changes on several bits may pulse in the same cycle.
REQ-026 Latency for a clean step with PRESCALE=1: gpio_o updates on rising edge 2+DEBOUNCE_TICKS after the first edge that samples the new pad level.
REQ-027 Counters shall never overflow: cnt[i] is bounded at DEBOUNCE_TICKS-1.
REQ-028 No bus interface: this block has no registers and no software-visible state.

Reset
REQ-029 While rst_i=1, immediately and asynchronously: sync1, sync2 and gpio_o shall equal INIT_VAL.
REQ-030 While rst_i=1: prescaler and all cnt[i] shall be 0; rise_o, fall_o and change_o shall be 0.
REQ-031 Reset asserted mid-count shall discard all progress.
REQ-032 After rst_i deassertion: first tick after PRESCALE cycles; a pad already differing from INIT_VAL is accepted after the normal debounce latency and produces edge pulses.

Verification
REQ-033 Clean step (PRESCALE=1, TICKS=3, INIT 0): gpio_i[0] 0->1 and held -> gpio_o[0]=1 on the 5th edge; rise_o[0] and change_o high for exactly that one cycle.
REQ-034 Glitch reject (PRESCALE=1, TICKS=3): gpio_i[2] high for 2 cycles, then low -> gpio_o stays 0x00; no pulses.
REQ-035 Prescaled (PRESCALE=4, TICKS=2): gpio_i[7] 1->0 held 20 cycles after gpio_o=0x80 -> gpio_o=0x00 on the 2nd tick after sync2 falls; fall_o=0x80 for one cycle; prescaler wrap 3->0 checked.
REQ-036 Bypass (TICKS=4): bypass_i=0x01, gpio_i[0] toggled every 2 cycles -> gpio_o[0] follows with 2-cycle lag, pulses on every toggle; bit 1 toggled the same way does not change.
REQ-037 Reset mid-count (TICKS=4): mismatch held for 3 ticks, rst_i pulsed high for 1 cycle -> gpio_o=INIT_VAL and cnt=0 immediately; acceptance needs a full 4 ticks after release.
REQ-038 Multi-bit: gpio_i 0x00->0x5A simultaneously -> gpio_o=0x5A in one cycle; rise_o=0x5A; change_o=1 for one cycle.

Source files
------------

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-bit 2-flop synchronizer plus tick-based debouncer with registered edge pulses.
module gpio_debounce #(
   parameter int                   BUS_WIDTH      = 8,
   parameter int                   PRESCALE       = 1,
   parameter int                   DEBOUNCE_TICKS = 4,
   parameter logic [BUS_WIDTH-1:0] INIT_VAL       = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [BUS_WIDTH-1:0] gpio_i,
   input  logic [BUS_WIDTH-1:0] bypass_i,
   output logic [BUS_WIDTH-1:0] gpio_o,
   output logic [BUS_WIDTH-1:0] rise_o,
   output logic [BUS_WIDTH-1:0] fall_o,
   output logic                 change_o
);
   localparam int CNT_W = DEBOUNCE_TICKS > 1 ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam int PS_W  = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
   logic [BUS_WIDTH-1:0]            sync1, sync2, gpio_nxt;
   logic [BUS_WIDTH-1:0][CNT_W-1:0] cnt, cnt_nxt;
   logic [PS_W-1:0]                 ps_cnt;
   logic                            tick;
   assign tick = ps_cnt == PS_MAX;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ps_cnt <= '0;
      else ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
   end
   // A match clears the count immediately, so a glitch never keeps partial credit.
   always_comb begin
      gpio_nxt = gpio_o;
      cnt_nxt  = cnt;
      for (int i = 0; i < BUS_WIDTH; i++) begin
         if (bypass_i[i]) begin
            gpio_nxt[i] = sync2[i];
            cnt_nxt[i]  = '0;
         end else if (sync2[i] == gpio_o[i]) begin
            cnt_nxt[i] = '0;
         end else if (tick) begin
            gpio_nxt[i] = cnt[i] == CNT_MAX ? sync2[i] : gpio_o[i];
            cnt_nxt[i]  = cnt[i] == CNT_MAX ? '0 : cnt[i] + 1'b1;
         end
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1    <= INIT_VAL;
         sync2    <= INIT_VAL;
         gpio_o   <= INIT_VAL;
         cnt      <= '0;
         rise_o   <= '0;
         fall_o   <= '0;
         change_o <= 1'b0;
      end else begin
         sync1    <= gpio_i;
         sync2    <= sync1;
         gpio_o   <= gpio_nxt;
         cnt      <= cnt_nxt;
         rise_o   <= gpio_nxt & ~gpio_o;
         fall_o   <= ~gpio_nxt & gpio_o;
         change_o <= |(gpio_nxt ^ gpio_o);
      end
   end
endmodule
